alu_issue_seq: RTL
==================

ALU_ISSUE_SEQ -- requirements
Module: alu_issue_seq

Interface
REQ-001 Parameter: DEPTH, default 4, number of command-FIFO entries (power of two, at least 2).
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  command offered.
REQ-005 Port: in_ready  output  1  command FIFO can accept.
REQ-006 Port: in_opt / in_a / in_b  input  4/4/4  opcode and operands.
REQ-007 Port: alu_opt / alu_a / alu_b  output  4/4/4  registered drive to the downstream ALU.
REQ-008 Port: alu_res  input  8  ALU registered result; valid one clk after operands are sampled.
REQ-009 Port: res_valid  output  1  result available.
REQ-010 Port: res_ready  input  1  consumer accepts result.
REQ-011 Port: res_data / res_opt  output  8/4  result and its originating opcode.
REQ-012 Port: res_err  output  1  result flagged (divide-by-zero or illegal opcode).
REQ-013 Port: busy  output  1  FIFO not empty or FSM not IDLE.

Function
REQ-014 FIFO push SHALL occur when in_valid && in_ready; in_ready = (count != DEPTH), with no full-bypass.
REQ-015 Pointers SHALL wrap modulo DEPTH; count SHALL have width clog2(DEPTH)+1.
REQ-016 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-017 FSM states SHALL be IDLE, ISSUE, CAPTURE, HOLD.
REQ-018 IDLE with FIFO non-empty SHALL pop the head into alu_opt/alu_a/alu_b and go to ISSUE; IDLE with FIFO empty SHALL stay in IDLE.
REQ-019 ISSUE SHALL hold the ALU drive stable for one cycle, then go to CAPTURE.
REQ-020 CAPTURE SHALL register alu_res into res_data, the opcode into res_opt, and the error bit into res_err, then go to HOLD.
REQ-021 HOLD SHALL assert res_valid; on res_ready it SHALL go to IDLE; otherwise res_data, res_opt and res_err SHALL stay stable.
REQ-022 Latency SHALL be: pop edge to res_valid high = 3 clk; sustained throughput = one result per 4 clk.
REQ-023 res_err SHALL be 1 when opt==4'b0011 && b==0, or when opt==4'b1111; in those cases res_data SHALL be forced to 8'h00.
REQ-024 The ALU drive SHALL change only on the IDLE-to-ISSUE transition.

Reset
REQ-025 When reset is high at a clk edge: FIFO empty, pointers 0, FSM IDLE, alu_opt/alu_a/alu_b=0, res_valid=0, res_data=0, res_opt=0, res_err=0.
REQ-026 Reset mid-operation SHALL discard all queued and in-flight commands; no result SHALL appear afterward.
REQ-027 During reset in_ready SHALL be 0; it SHALL be 1 in the first cycle after reset deasserts.

Structure
REQ-028 A shared package SHALL hold the 4-bit opcode constants (ADD=0000 ... NOT=1110, ILLEGAL=1111) and the FSM state encoding.
REQ-029 The FIFO SHALL be one sub-module named alu_cmd_fifo (12-bit entries, DEPTH parameter).

Verification
REQ-030 Push {0000,3,5} with res_ready=1 -> res_data=8'h08, res_opt=0000, res_err=0, res_valid high 3 clk after the pop.
REQ-031 Push {0001,3,5} -> res_data=8'hFE; push {0010,15,15} -> res_data=8'hE1, in push order.
REQ-032 Push {0011,7,0} -> res_err=1 and res_data=8'h00; push {1111,1,1} -> res_err=1.
REQ-033 With res_ready=0, push 6 commands -> 1 in flight plus 4 queued, in_ready=0, res_data stable; then res_ready=1 -> all 5 results drain in order and in_ready returns to 1.
REQ-034 Assert reset for 1 clk while in CAPTURE with 2 commands queued -> res_valid=0, busy=0, and no results thereafter.

Source files
------------

// File: rtl/alu_issue_seq_pkg.sv
// Shared opcode map, FSM state encoding and command layout for the ALU issue sequencer.
package alu_issue_seq_pkg;

  localparam logic [3:0] OP_ADD     = 4'b0000;
  localparam logic [3:0] OP_SUB     = 4'b0001;
  localparam logic [3:0] OP_MUL     = 4'b0010;
  localparam logic [3:0] OP_DIV     = 4'b0011;
  localparam logic [3:0] OP_AND     = 4'b0100;
  localparam logic [3:0] OP_OR      = 4'b0101;
  localparam logic [3:0] OP_XOR     = 4'b0110;
  localparam logic [3:0] OP_SHL     = 4'b0111;
  localparam logic [3:0] OP_SHR     = 4'b1000;
  localparam logic [3:0] OP_MOD     = 4'b1001;
  localparam logic [3:0] OP_MIN     = 4'b1010;
  localparam logic [3:0] OP_MAX     = 4'b1011;
  localparam logic [3:0] OP_INC     = 4'b1100;
  localparam logic [3:0] OP_DEC     = 4'b1101;
  localparam logic [3:0] OP_NOT     = 4'b1110;
  localparam logic [3:0] OP_ILLEGAL = 4'b1111;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ISSUE   = 2'd1;
  localparam logic [1:0] ST_CAPTURE = 2'd2;
  localparam logic [1:0] ST_HOLD    = 2'd3;

  typedef struct packed {
    logic [3:0] opt;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  // Divide by zero and the reserved opcode both produce a flagged, zeroed result.
  function automatic logic cmd_err(input logic [3:0] opt, input logic [3:0] b);
    return ((opt == OP_DIV) && (b == 4'd0)) || (opt == OP_ILLEGAL);
  endfunction

endpackage

// File: rtl/alu_issue_seq_if.sv
// Command, ALU-drive and result signals of the issue sequencer, bundled as one interface.
interface alu_issue_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_opt;
  logic [3:0] in_a;
  logic [3:0] in_b;
  logic [3:0] alu_opt;
  logic [3:0] alu_a;
  logic [3:0] alu_b;
  logic [7:0] alu_res;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [3:0] res_opt;
  logic       res_err;
  logic       busy;

  modport slave (
    input  in_valid, in_opt, in_a, in_b, alu_res, res_ready,
    output in_ready, alu_opt, alu_a, alu_b, res_valid, res_data, res_opt, res_err, busy
  );

  modport master (
    output in_valid, in_opt, in_a, in_b, alu_res, res_ready,
    input  in_ready, alu_opt, alu_a, alu_b, res_valid, res_data, res_opt, res_err, busy
  );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: DEPTH entries of {opt,a,b}, head visible combinationally for same-edge pop.
module alu_cmd_fifo
  import alu_issue_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  cmd_t                     push_data,
  input  logic                     pop,
  output cmd_t                     pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  cmd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W:0]   count_reg;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count_reg != FULL_CNT);
  assign do_pop  = pop && (count_reg != '0);

  // DEPTH is a power of two, so pointer overflow is exactly the modulo wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CNT_ONE;
        2'b01:   count_reg <= count_reg - CNT_ONE;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  assign pop_data = mem[rd_ptr_reg];
  assign empty    = (count_reg == '0);
  assign count    = count_reg;

endmodule

// File: rtl/alu_issue_seq.sv
// Issues queued commands one at a time to a registered ALU and holds each result until consumed.
module alu_issue_seq
  import alu_issue_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  alu_issue_seq_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [1:0]       state_reg;
  logic [1:0]       state_next;
  logic [3:0]       alu_opt_reg;
  logic [3:0]       alu_a_reg;
  logic [3:0]       alu_b_reg;
  logic [7:0]       res_data_reg;
  logic [3:0]       res_opt_reg;
  logic             res_err_reg;
  logic             push;
  logic             pop;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  cmd_t             push_cmd;
  cmd_t             head_cmd;
  logic             cap_err;

  // in_ready is held low while reset is asserted, and never bypasses a full FIFO.
  assign bus.in_ready = !reset && (fifo_count != FULL_CNT);
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state_reg == ST_IDLE) && !fifo_empty;
  assign push_cmd     = '{opt: bus.in_opt, a: bus.in_a, b: bus.in_b};

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_cmd),
    .pop       (pop),
    .pop_data  (head_cmd),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (!fifo_empty) state_next = ST_ISSUE;
      ST_ISSUE:   state_next = ST_CAPTURE;
      ST_CAPTURE: state_next = ST_HOLD;
      ST_HOLD:    if (bus.res_ready) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  assign cap_err = cmd_err(alu_opt_reg, alu_b_reg);

  // ALU drive is loaded only on the pop, so it stays put through ISSUE and CAPTURE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      alu_opt_reg  <= '0;
      alu_a_reg    <= '0;
      alu_b_reg    <= '0;
      res_data_reg <= '0;
      res_opt_reg  <= '0;
      res_err_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (pop) begin
        alu_opt_reg <= head_cmd.opt;
        alu_a_reg   <= head_cmd.a;
        alu_b_reg   <= head_cmd.b;
      end
      if (state_reg == ST_CAPTURE) begin
        res_data_reg <= cap_err ? 8'h00 : bus.alu_res;
        res_opt_reg  <= alu_opt_reg;
        res_err_reg  <= cap_err;
      end
    end
  end

  assign bus.alu_opt   = alu_opt_reg;
  assign bus.alu_a     = alu_a_reg;
  assign bus.alu_b     = alu_b_reg;
  assign bus.res_valid = (state_reg == ST_HOLD);
  assign bus.res_data  = res_data_reg;
  assign bus.res_opt   = res_opt_reg;
  assign bus.res_err   = res_err_reg;
  assign bus.busy      = !fifo_empty || (state_reg != ST_IDLE);

endmodule
